i2s_master_tx: RTL and testbench



---
 rtl/i2s_master_tx.sv | 201 ++++++++++++++++++++
 tb/tb_i2s_master_tx.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_master_tx.sv
// ============================================================================
// i2s_master_tx
// ----------------------------------------------------------------------------
// I2S master transmitter. It takes 24-bit left/right sample pairs through a
// one-deep holding register. It generates the bit clock (I2S_sclk) and the word
// select (I2S_ws), and shifts every pair out MSB-first in standard I2S format.
// Each channel's MSB goes out one sclk after the ws transition. The outputs
// connect pin-for-pin to the I2S_Slave receiver.
//
// Frame structure (64 sclk slots, sclk period = 2^DIV_W clk):
//   slot  0      : 0 (I2S one-bit delay after ws falls)
//   slots 1..24  : left sample, MSB first         (ws = 0 for slots 0..31)
//   slots 25..31 : 0
//   slot  32     : 0 (I2S one-bit delay after ws rises)
//   slots 33..56 : right sample, MSB first        (ws = 1 for slots 32..63)
//   slots 57..63 : 0
//
// Optional feature macro:
//   I2S_TX_MUTE_ON_UNDERRUN_EN
//     defined     : a frame that loads with an empty holding register sends
//                   L = R = 0.
//     not defined : such a frame resends the last loaded pair. The holding
//                   registers keep their contents, so that pair is still
//                   available.
//   The underrun pulse is generated in both builds.
//
// Ports:
//   clk        in   system clock, every flop on its rising edge
//   rst_n      in   synchronous, active-low reset
//   lft_smpl   in   24-bit signed left sample
//   rght_smpl  in   24-bit signed right sample
//   wrt_smpl   in   1-cycle strobe capturing lft_smpl/rght_smpl
//   I2S_sclk   out  bit clock, 50 % duty (registered div_cnt MSB)
//   I2S_ws     out  word select, 0 = left, 1 = right
//   I2S_data   out  serial data, changes on the sclk falling edge
//   smpl_req   out  1-cycle pulse after each frame load (request next pair)
//   hold_full  out  holding register contains an unsent pair
//   underrun   out  1-cycle pulse after a frame load that found hold_full=0
// ============================================================================
module i2s_master_tx #(
    parameter int DIV_W = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic signed [23:0] lft_smpl,
    input  logic signed [23:0] rght_smpl,
    input  logic               wrt_smpl,
    output logic               I2S_sclk,
    output logic               I2S_ws,
    output logic               I2S_data,
    output logic               smpl_req,
    output logic               hold_full,
    output logic               underrun
);

    localparam int DATA_W  = 24;
    localparam int SLOT_W  = 32;
    localparam int FRAME_W = 2 * SLOT_W;
    // Zero bits that follow each sample inside its 32-slot half frame.
    localparam int PAD_W   = SLOT_W - 1 - DATA_W;
    localparam int BIT_W   = 6;

    localparam logic [DIV_W-1:0] DIV_ONE = DIV_W'(1);
    localparam logic [BIT_W-1:0] BIT_ONE = BIT_W'(1);
    localparam logic [BIT_W-1:0] BIT_MAX = '1;

    // ------------------------------------------------------------------------
    // Assemble the 64-bit frame image in transmit order (bit 63 goes first).
    // ------------------------------------------------------------------------
    function automatic logic [FRAME_W-1:0] build_frame(
        input logic signed [DATA_W-1:0] l,
        input logic signed [DATA_W-1:0] r
    );
        build_frame = {1'b0, l, {PAD_W{1'b0}}, 1'b0, r, {PAD_W{1'b0}}};
    endfunction

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic        [DIV_W-1:0]   div_cnt_q,   div_cnt_d;
    logic        [BIT_W-1:0]   bit_cnt_q,   bit_cnt_d;
    logic                      sclk_q,      sclk_d;
    logic                      ws_q,        ws_d;
    logic        [FRAME_W-1:0] shift_q,     shift_d;
    logic signed [DATA_W-1:0]  hold_l_q,    hold_l_d;
    logic signed [DATA_W-1:0]  hold_r_q,    hold_r_d;
    logic                      hold_full_q, hold_full_d;
    logic                      smpl_req_q,  smpl_req_d;
    logic                      underrun_q,  underrun_d;

    logic                      fall_edge;
    logic                      frame_load;
    logic signed [DATA_W-1:0]  load_l;
    logic signed [DATA_W-1:0]  load_r;

    // ------------------------------------------------------------------------
    // Bit-clock timing
    // ------------------------------------------------------------------------
    always_comb begin
        // The sclk falling edge is the clk edge on which div_cnt wraps to 0.
        fall_edge  = &div_cnt_q;
        // The frame load is the falling edge on which bit_cnt wraps 63 -> 0.
        frame_load = fall_edge && (bit_cnt_q == BIT_MAX);

        div_cnt_d  = div_cnt_q + DIV_ONE;
        // sclk follows the counter MSB without lag. It is low for the first
        // half period, so the falling edge lines up with the counter wrap.
        sclk_d     = div_cnt_d[DIV_W-1];

        bit_cnt_d  = bit_cnt_q;
        ws_d       = ws_q;
        if (fall_edge) begin
            bit_cnt_d = bit_cnt_q + BIT_ONE;
            ws_d      = bit_cnt_d[BIT_W-1];
        end
    end

    // ------------------------------------------------------------------------
    // Pair selected for the next frame
    // ------------------------------------------------------------------------
    always_comb begin
        load_l = hold_l_q;
        load_r = hold_r_q;
`ifdef I2S_TX_MUTE_ON_UNDERRUN_EN
        if (!hold_full_q) begin
            load_l = '0;
            load_r = '0;
        end
`endif
    end

    // ------------------------------------------------------------------------
    // Shift register and holding register
    // ------------------------------------------------------------------------
    always_comb begin
        shift_d = shift_q;
        if (frame_load) begin
            shift_d = build_frame(load_l, load_r);
        end else if (fall_edge) begin
            shift_d = {shift_q[FRAME_W-2:0], 1'b0};
        end

        hold_l_d    = hold_l_q;
        hold_r_d    = hold_r_q;
        hold_full_d = hold_full_q;
        if (frame_load) begin
            hold_full_d = 1'b0;
        end
        // A write takes priority over the load's clear. The load above has
        // already used the old contents. The new pair waits for the next frame.
        if (wrt_smpl) begin
            hold_l_d    = lft_smpl;
            hold_r_d    = rght_smpl;
            hold_full_d = 1'b1;
        end

        smpl_req_d = frame_load;
        underrun_d = frame_load && !hold_full_q;
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // bit_cnt starts at 63, so the first falling edge is a frame load.
            div_cnt_q   <= '0;
            bit_cnt_q   <= BIT_MAX;
            sclk_q      <= 1'b0;
            ws_q        <= 1'b1;
            shift_q     <= '0;
            hold_l_q    <= '0;
            hold_r_q    <= '0;
            hold_full_q <= 1'b0;
            smpl_req_q  <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            div_cnt_q   <= div_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            sclk_q      <= sclk_d;
            ws_q        <= ws_d;
            shift_q     <= shift_d;
            hold_l_q    <= hold_l_d;
            hold_r_q    <= hold_r_d;
            hold_full_q <= hold_full_d;
            smpl_req_q  <= smpl_req_d;
            underrun_q  <= underrun_d;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign I2S_sclk  = sclk_q;
    assign I2S_ws    = ws_q;
    assign I2S_data  = shift_q[FRAME_W-1];
    assign smpl_req  = smpl_req_q;
    assign hold_full = hold_full_q;
    assign underrun  = underrun_q;

endmodule

// File: tb/tb_i2s_master_tx.sv
module tb_i2s_master_tx;

    localparam int DIV_W     = 5;
    localparam int FRAME_CLK = 64 * (1 << DIV_W);   // 2048

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic signed [23:0] lft_smpl = '0;
    logic signed [23:0] rght_smpl = '0;
    logic               wrt_smpl = 1'b0;
    logic               I2S_sclk, I2S_ws, I2S_data;
    logic               smpl_req, hold_full, underrun;

    i2s_master_tx #(.DIV_W(DIV_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .lft_smpl  (lft_smpl),
        .rght_smpl (rght_smpl),
        .wrt_smpl  (wrt_smpl),
        .I2S_sclk  (I2S_sclk),
        .I2S_ws    (I2S_ws),
        .I2S_data  (I2S_data),
        .smpl_req  (smpl_req),
        .hold_full (hold_full),
        .underrun  (underrun)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct packed {
        logic [23:0] l;
        logic [23:0] r;
        logic        ur;
    } exp_t;

    exp_t exp_q[$];

    task automatic chk(input string nm, input logic [47:0] act, input logic [47:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, req, $time);
        end
    endtask

    task automatic push_exp(input logic [23:0] l, input logic [23:0] r, input logic ur);
        exp_t e;
        e.l  = l;
        e.r  = r;
        e.ur = ur;
        exp_q.push_back(e);
    endtask

    // Stimulus acts just after the falling clk edge, away from the active edge.
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wr(input logic [23:0] l, input logic [23:0] r);
        lft_smpl  = l;
        rght_smpl = r;
        wrt_smpl  = 1'b1;
        tick();
        wrt_smpl  = 1'b0;
    endtask

    // Returns the number of ticks until smpl_req is seen (bounded).
    task automatic wait_req(output int k);
        k = 0;
        do begin
            tick();
            k++;
        end while (!smpl_req && k < 4000);
        if (!smpl_req) begin
            n_cmp++;
            n_err++;
            $display("FAIL smpl_req_timeout: got none in %0d cycles, expected a pulse", k);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_sclk"},      I2S_sclk,  1'b0);
        chk({tag, "_ws"},        I2S_ws,    1'b1);
        chk({tag, "_data"},      I2S_data,  1'b0);
        chk({tag, "_smpl_req"},  smpl_req,  1'b0);
        chk({tag, "_hold_full"}, hold_full, 1'b0);
        chk({tag, "_underrun"},  underrun,  1'b0);
    endtask

    // ------------------------------------------------------------------
    // Monitor: an I2S receiver model plus load-pulse bookkeeping
    // ------------------------------------------------------------------
    initial begin
        logic        prev_sclk;
        logic        prev_ws;
        logic        active;
        logic        zero_bad;
        logic        ur_lat;
        logic        req_seen;
        logic [23:0] lw;
        logic [23:0] rw;
        int          bitpos;
        int          last_req;
        exp_t        e;
        prev_sclk = 1'b0; prev_ws = 1'b1; active = 1'b0; zero_bad = 1'b0;
        ur_lat = 1'b0; req_seen = 1'b0; lw = '0; rw = '0; bitpos = 0; last_req = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_sclk = 1'b0;
                prev_ws   = 1'b1;
                active    = 1'b0;
                req_seen  = 1'b0;
                bitpos    = 0;
            end else begin
                if (smpl_req) begin
                    ur_lat = underrun;
                    if (req_seen) chk("smpl_req_period", 48'(cyc - last_req), 48'(FRAME_CLK));
                    req_seen = 1'b1;
                    last_req = cyc;
                end
                if (I2S_sclk && !prev_sclk) begin
                    if (I2S_ws != prev_ws) begin
                        bitpos = 0;
                        if (!I2S_ws) begin
                            active   = 1'b1;
                            zero_bad = 1'b0;
                        end
                    end else begin
                        bitpos++;
                    end
                    prev_ws = I2S_ws;
                    if (active) begin
                        if (bitpos >= 1 && bitpos <= 24) begin
                            if (!I2S_ws) lw = {lw[22:0], I2S_data};
                            else         rw = {rw[22:0], I2S_data};
                        end else if (I2S_data) begin
                            zero_bad = 1'b1;
                        end
                        if (I2S_ws && bitpos == 31) begin
                            if (exp_q.size() == 0) begin
                                n_cmp++;
                                n_err++;
                                $display("FAIL frame_unexpected: got L=%0h R=%0h, expected no frame", lw, rw);
                            end else begin
                                e = exp_q.pop_front();
                                chk("frame_left",  lw,       e.l);
                                chk("frame_right", rw,       e.r);
                                chk("frame_underrun", ur_lat, e.ur);
                                chk("frame_zero_slots", zero_bad, 1'b0);
                            end
                            active = 1'b0;
                        end
                    end
                end
                prev_sclk = I2S_sclk;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        int k;
        logic [23:0] v;
        logic [23:0] ur_l;
        logic [23:0] ur_r;

        // Reset held for 5 cycles.
        rst_n = 1'b0;
        repeat (5) @(posedge clk);
        tick();
        chk_reset_outputs("reset");
        rst_n = 1'b1;

        // Loopback pair written before the first load.
        tick(); tick(); tick();            // 3 cycles after release
        wr(24'hABCDEF, 24'h123456);        // 4
        push_exp(24'hABCDEF, 24'h123456, 1'b0);
        tick();                            // 5
        chk("hold_full_after_write", hold_full, 1'b1);
        wait_req(k);
        chk("first_req_latency", 48'(k + 5), 48'd32);
        chk("hold_clear_on_load", hold_full, 1'b0);
        chk("first_load_no_underrun", underrun, 1'b0);

        // Streaming: 20 incrementing pairs.
        for (int n = 1; n <= 20; n++) begin
            v = 24'(n);
            wr(v, ~v);
            push_exp(v, ~v, 1'b0);
            wait_req(k);
        end

        // Underrun: one pair, then no more writes.
        wr(24'h7FFFFF, 24'h800000);
        push_exp(24'h7FFFFF, 24'h800000, 1'b0);
        wait_req(k);
`ifdef I2S_TX_MUTE_ON_UNDERRUN_EN
        ur_l = 24'h000000; ur_r = 24'h000000;
`else
        ur_l = 24'h7FFFFF; ur_r = 24'h800000;
`endif
        push_exp(ur_l, ur_r, 1'b1);
        wait_req(k);
        chk("underrun_pulse", underrun, 1'b1);

        // Coincident write on the next load edge, with the holding register empty.
        push_exp(ur_l, ur_r, 1'b1);
        repeat (FRAME_CLK - 1) tick();
        lft_smpl  = 24'h111111;
        rght_smpl = 24'h222222;
        wrt_smpl  = 1'b1;
        tick();
        wrt_smpl  = 1'b0;
        chk("coincident_on_load", smpl_req, 1'b1);
        chk("coincident_hold_full", hold_full, 1'b1);
        push_exp(24'h111111, 24'h222222, 1'b0);
        wait_req(k);

        // Mid-frame reset at bit_cnt = 40, with an unsent pair pending.
        wait_req(k);
        wr(24'h555555, 24'h666666);
        repeat (40 * (1 << DIV_W) + 8) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk_reset_outputs("midreset");
        push_exp(24'h000000, 24'h000000, 1'b1);
        wait_req(k);
        chk("req_after_midreset", 48'(k), 48'd32);
        wr(24'h333333, 24'h444444);
        push_exp(24'h333333, 24'h444444, 1'b0);
        wait_req(k);

        // Drain the scoreboard.
        k = 0;
        while (exp_q.size() != 0 && k < 3000) begin
            tick();
            k++;
        end
        chk("scoreboard_drained", 48'(exp_q.size()), 48'd0);

        repeat (4) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no completion by %0t, expected completion", $time);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
        $fatal(1, "watchdog");
    end

endmodule
